// File: rtl/device_uart.sv
// device_uart: memory-mapped 8N1 UART for the cluster device space.
//
// Ports
//   clk              sole clock, all state on the rising edge
//   reset            asynchronous, active-low reset
//   device_core_id   ID of the core issuing the current request
//   device_write_en  single-cycle write strobe
//   device_read_en   single-cycle read strobe
//   device_addr      register address (full 10-bit decode)
//   device_data_out  write data from the cluster
//   device_data_in   registered read data, valid the cycle after a read
//   uart_tx          serial transmit line, idle high
//   uart_rx          serial receive line, asynchronous to clk
//
// Register map
//   0x000 STATUS      {11'b0, tx_idle, framing_err, overrun, rx_valid, tx_full}
//   0x001 TX_DATA     write pushes data[7:0] into the TX FIFO
//   0x002 RX_DATA     {8'h00, rx_byte} when valid, else 0; read clears valid
//   0x003 LAST_WRITER {12'h000, core id of last accepted TX_DATA write}
module device_uart #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int TX_FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  device_core_id,
  input  logic        device_write_en,
  input  logic        device_read_en,
  input  logic [9:0]  device_addr,
  input  logic [15:0] device_data_out,
  output logic [15:0] device_data_in,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(TX_FIFO_DEPTH);

  localparam logic [9:0] ADDR_STATUS      = 10'h000;
  localparam logic [9:0] ADDR_TX_DATA     = 10'h001;
  localparam logic [9:0] ADDR_RX_DATA     = 10'h002;
  localparam logic [9:0] ADDR_LAST_WRITER = 10'h003;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Upper write-data byte has no destination.
  logic unused_hi;
  assign unused_hi = ^device_data_out[15:8];

  logic wr_tx, rd_status, rd_rx;
  assign wr_tx     = device_write_en && (device_addr == ADDR_TX_DATA);
  assign rd_status = device_read_en  && (device_addr == ADDR_STATUS);
  assign rd_rx     = device_read_en  && (device_addr == ADDR_RX_DATA);

  // TX FIFO
  logic [7:0]       fifo_mem_q [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             tx_pop, push_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = wr_tx && ((count_q < FIFO_FULL) || tx_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (tx_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !tx_pop)      count_d = count_q + 1'b1;
    else if (!push_ok && tx_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= device_data_out[7:0];
  end

  // TX FSM
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (count_q != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_mem_q[rd_ptr_q];
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) tx_state_d = S_IDLE;
        else                      tx_cnt_d   = tx_cnt_q + 1'b1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Decoded straight from the state flop so reset forces the line high at once.
  always_comb begin
    case (tx_state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // RX synchronizer plus one extra flop for falling-edge detection
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  // RX FSM
  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_done, rx_ferr;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: begin
        // Mid-start sample; a high line here was only a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = S_IDLE;
          rx_done    = rx_s2_q;
          rx_ferr    = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Status flags, RX holding register, last writer, read data
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        ferr_q, ferr_d;
  logic [3:0]  last_writer_q, last_writer_d;
  logic [15:0] data_in_q, data_in_d;
  logic        tx_full, tx_idle;

  assign tx_full = (count_q == FIFO_FULL);
  assign tx_idle = (count_q == '0) && (tx_state_q == S_IDLE);

  always_comb begin
    rx_byte_d     = rx_byte_q;
    rx_valid_d    = rx_valid_q;
    overrun_d     = overrun_q;
    ferr_d        = ferr_q;
    last_writer_d = last_writer_q;
    if (rd_rx)     rx_valid_d = 1'b0;
    if (rd_status) begin
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
    end
    // Sets come after clears so an event in the read cycle is not lost.
    if (rx_done) begin
      if (!rx_valid_q || rd_rx) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (rx_ferr) ferr_d = 1'b1;
    if (push_ok) last_writer_d = device_core_id;
  end

  always_comb begin
    data_in_d = data_in_q;
    if (device_read_en) begin
      case (device_addr)
        ADDR_STATUS:      data_in_d = {11'h000, tx_idle, ferr_q, overrun_q, rx_valid_q, tx_full};
        ADDR_RX_DATA:     data_in_d = rx_valid_q ? {8'h00, rx_byte_q} : 16'h0000;
        ADDR_LAST_WRITER: data_in_d = {12'h000, last_writer_q};
        default:          data_in_d = 16'h0000;
      endcase
    end
  end

  assign device_data_in = data_in_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tx_state_q    <= S_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= S_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      ferr_q        <= 1'b0;
      last_writer_q <= '0;
      data_in_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      rx_s1_q       <= uart_rx;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_valid_q    <= rx_valid_d;
      overrun_q     <= overrun_d;
      ferr_q        <= ferr_d;
      last_writer_q <= last_writer_d;
      data_in_q     <= data_in_d;
    end
  end

  // Datapath registers; only meaningful while qualified by FSM/valid state.
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
    rx_byte_q  <= rx_byte_d;
  end

endmodule

// File: tb/tb_device_uart.sv
// tb_device_uart: scoreboard bench for device_uart. TX bytes are queued when
// written and checked by a serial monitor; register reads are checked one
// cycle after the strobe.
module tb_device_uart;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB + 1;

  localparam logic [9:0] A_STATUS = 10'h000;
  localparam logic [9:0] A_TX     = 10'h001;
  localparam logic [9:0] A_RX     = 10'h002;
  localparam logic [9:0] A_LAST   = 10'h003;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  device_core_id = '0;
  logic        device_write_en = 1'b0;
  logic        device_read_en = 1'b0;
  logic [9:0]  device_addr = '0;
  logic [15:0] device_data_out = '0;
  logic [15:0] device_data_in;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  device_uart #(.CLOCKS_PER_BIT(CPB), .TX_FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .device_core_id  (device_core_id),
    .device_write_en (device_write_en),
    .device_read_en  (device_read_en),
    .device_addr     (device_addr),
    .device_data_out (device_data_out),
    .device_data_in  (device_data_in),
    .uart_tx         (uart_tx),
    .uart_rx         (uart_rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int reset_epoch = 0;
  logic b2b_en = 1'b0;
  int b2b_frames = 0;
  int last_start = 0;
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge reset) reset_epoch <= reset_epoch + 1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic dev_write(input logic [9:0] addr, input logic [15:0] data, input logic [3:0] id);
    @(posedge clk); #1;
    device_write_en = 1'b1;
    device_addr     = addr;
    device_data_out = data;
    device_core_id  = id;
    @(posedge clk); #1;
    device_write_en = 1'b0;
  endtask

  task automatic dev_read(input logic [9:0] addr, output logic [15:0] data);
    @(posedge clk); #1;
    device_read_en = 1'b1;
    device_addr    = addr;
    @(posedge clk); #1;
    device_read_en = 1'b0;
    data = device_data_in;
  endtask

  task automatic check_read(input logic [9:0] addr, input logic [15:0] exp, input string tag);
    logic [15:0] d;
    dev_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    @(posedge clk); #2;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    check_eq("tx_drain", 16'(exp_q.size()), 16'd0);
  endtask

  // Serial TX monitor: decodes each frame at bit midpoints.
  initial begin : tx_monitor
    logic [7:0] got;
    logic [7:0] exp;
    logic start_ok, stop_ok;
    int ep, st;
    forever begin
      @(negedge clk);
      if (reset && uart_tx == 1'b0) begin
        ep = reset_epoch;
        st = cyc;
        repeat (CPB / 2 - 1) @(negedge clk);
        start_ok = (uart_tx == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        stop_ok = uart_tx;
        if (ep == reset_epoch) begin
          check_eq("tx_start_bit", 16'(start_ok), 16'd1);
          check_eq("tx_stop_bit", 16'(stop_ok), 16'd1);
          check_eq("tx_frame_expected", 16'(exp_q.size() > 0), 16'd1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_eq("tx_byte", {8'h00, got}, {8'h00, exp});
          end
          if (b2b_en) begin
            if (b2b_frames > 0) check_eq("tx_b2b_period", 16'(st - last_start), 16'(FRAME));
            b2b_frames++;
          end
          last_start = st;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : main
    int n;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check_eq("rst_uart_tx", 16'(uart_tx), 16'd1);
    check_eq("rst_data_in", device_data_in, 16'h0000);
    @(negedge clk); reset = 1'b1;
    check_read(A_STATUS, 16'h0010, "status_after_reset");
    check_read(A_LAST, 16'h0000, "last_writer_reset");
    check_read(A_RX, 16'h0000, "rx_data_empty");

    // Single byte from core 5, start bit length
    exp_q.push_back(8'h55);
    dev_write(A_TX, 16'hAB55, 4'd5);
    n = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check_eq("tx_start_seen", 16'(uart_tx), 16'd0);
    n = 0;
    while (uart_tx === 1'b0 && n < 100) begin @(negedge clk); n++; end
    check_eq("tx_start_len", 16'(n), 16'(CPB));
    check_read(A_LAST, 16'h0005, "last_writer_5");
    check_read(A_STATUS, 16'h0000, "status_tx_busy");
    wait_drain();

    // Ten writes while busy: 9 accepted, FIFO full, tenth dropped
    b2b_en = 1'b1;
    b2b_frames = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'hA0 ^ 8'(i * 37);
      exp_q.push_back(b);
      dev_write(A_TX, {8'hFF, b}, 4'(i + 1));
    end
    check_read(A_STATUS, 16'h0001, "status_fifo_full");
    dev_write(A_TX, 16'h00EE, 4'hC);
    check_read(A_LAST, 16'h0009, "last_writer_after_drop");
    check_read(A_STATUS, 16'h0001, "status_still_full");
    wait_drain();
    b2b_en = 1'b0;
    check_eq("b2b_frame_count", 16'(b2b_frames), 16'd9);

    // Simultaneous read and write strobes
    check_read(A_LAST, 16'h0009, "last_writer_pre_simul");
    exp_q.push_back(8'h81);
    @(posedge clk); #1;
    device_write_en = 1'b1;
    device_read_en  = 1'b1;
    device_addr     = A_TX;
    device_data_out = 16'h0081;
    device_core_id  = 4'd3;
    @(posedge clk); #1;
    device_write_en = 1'b0;
    device_read_en  = 1'b0;
    check_eq("simul_read_tx_addr", device_data_in, 16'h0000);
    check_read(A_LAST, 16'h0003, "last_writer_simul");

    // Unmapped addresses ignore writes and read zero
    dev_write(10'h201, 16'h0077, 4'hE);
    dev_write(10'h005, 16'h0066, 4'hD);
    check_read(A_LAST, 16'h0003, "last_writer_unmapped");
    check_read(10'h3FF, 16'h0000, "unmapped_read");
    wait_drain();

    // RX byte while TX busy
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    dev_write(A_TX, 16'h0011, 4'd1);
    dev_write(A_TX, 16'h0022, 4'd2);
    rx_send(8'hC3, 1'b1);
    repeat (4) @(posedge clk);
    check_read(A_STATUS, 16'h0002, "status_rx_valid");
    check_read(A_RX, 16'h00C3, "rx_data_c3");
    repeat (5) @(posedge clk); #1;
    check_eq("read_data_hold", device_data_in, 16'h00C3);
    check_read(A_RX, 16'h0000, "rx_data_cleared");
    wait_drain();
    check_read(A_STATUS, 16'h0010, "status_idle_after_rx");

    // Overrun
    rx_send(8'hA1, 1'b1);
    rx_send(8'h5E, 1'b1);
    repeat (4) @(posedge clk);
    check_read(A_STATUS, 16'h0016, "status_overrun");
    check_read(A_RX, 16'h00A1, "rx_data_first_kept");
    check_read(A_STATUS, 16'h0010, "status_overrun_cleared");

    // Framing error
    rx_send(8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    check_read(A_STATUS, 16'h0018, "status_framing");
    check_read(A_RX, 16'h0000, "rx_data_after_framing");
    check_read(A_STATUS, 16'h0010, "status_framing_cleared");

    // Short glitch is a false start
    @(posedge clk); #2;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk); #2;
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    check_read(A_STATUS, 16'h0010, "status_after_glitch");
    rx_send(8'h96, 1'b1);
    repeat (4) @(posedge clk);
    check_read(A_RX, 16'h0096, "rx_data_after_glitch");

    // Reset mid-frame
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A);
    dev_write(A_TX, 16'h0000, 4'd7);
    dev_write(A_TX, 16'h005A, 4'd7);
    check_read(A_LAST, 16'h0007, "last_writer_7");
    repeat (40) @(posedge clk); #3;
    check_eq("tx_low_before_reset", 16'(uart_tx), 16'd0);
    reset = 1'b0;
    #1;
    check_eq("reset_uart_tx", 16'(uart_tx), 16'd1);
    check_eq("reset_data_in", device_data_in, 16'h0000);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    check_read(A_STATUS, 16'h0010, "status_after_midframe_reset");
    check_read(A_LAST, 16'h0000, "last_writer_after_reset");
    repeat (400) @(posedge clk); #1;
    check_eq("tx_idle_after_reset", 16'(uart_tx), 16'd1);
    check_read(A_STATUS, 16'h0010, "status_fifo_lost");
    check_eq("tx_q_final_empty", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
